// File: rtl/lcd_char_writer.sv
// lcd_char_writer: takes bytes from the UART receiver over valid/ready and
// writes them to an HD44780-compatible 16x2 LCD on an 8-bit write-only bus.
// Runs the LCD power-up init itself and tracks the cursor column so that
// line 2 (0xC0) and line 1 (0x80) addresses are issued at wrap points.
// Optional build macro LCD_CTRL_CHAR_EN: CR (0x0D) moves to the other line
// and FF (0x0C) clears the display instead of being printed.
module lcd_char_writer #(
  parameter int PWRUP_CYC = 405_000,
  parameter int CMD_CYC   = 1_350,
  parameter int CLR_CYC   = 54_000,
  parameter int EN_CYC    = 14
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic [7:0] DATA_I,
  input  logic       VALID_I,
  output logic       READY_O,
  output logic       INIT_DONE_O,
  output logic       LCD_RS_O,
  output logic       LCD_RW_O,
  output logic       LCD_EN_O,
  output logic [7:0] LCD_DATA_O
);

  // Delay counter must hold the longest wait; never narrower than 19 bits.
  localparam int MAX_PC  = (PWRUP_CYC > CLR_CYC) ? PWRUP_CYC : CLR_CYC;
  localparam int MAX_EC  = (CMD_CYC > EN_CYC) ? CMD_CYC : EN_CYC;
  localparam int MAX_CYC = (MAX_PC > MAX_EC) ? MAX_PC : MAX_EC;
  localparam int CNT_RAW = $clog2(MAX_CYC + 1);
  localparam int CNT_W   = (CNT_RAW < 19) ? 19 : CNT_RAW;

  typedef enum logic [2:0] {
    ST_PWRUP, ST_INIT, ST_IDLE, ST_SETUP, ST_STROBE, ST_HOLD, ST_WAIT, ST_WRAP
  } state_t;

  // What the write cycle in flight is doing; decides where WAIT goes next.
  typedef enum logic [1:0] {
    K_INIT, K_CHAR, K_CMD
  } kind_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_term;
  logic             w_cnt_done;
  logic [2:0]       r_idx;
  logic [2:0]       w_idx_next;
  logic [4:0]       r_col;
  logic [4:0]       w_col_next;
  logic [4:0]       w_col_inc;
  kind_t            r_kind;
  kind_t            w_ld_kind;
  logic             w_ld;
  logic [7:0]       w_ld_data;
  logic             w_ld_rs;
  logic             w_is_clr;
  logic             r_rs;
  logic [7:0]       r_data;
  logic             r_en;
  logic             r_ready;
  logic             r_init_done;

  // Power-up command list: 8-bit/2-line twice, display on, clear, entry inc.
  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1: init_cmd = 8'h38;
      3'd2:       init_cmd = 8'h0C;
      3'd3:       init_cmd = 8'h01;
      default:    init_cmd = 8'h06;
    endcase
  endfunction

  assign w_is_clr   = !r_rs && (r_data == 8'h01);
  assign w_col_inc  = r_col + 5'd1;
  assign w_cnt_done = (r_cnt == w_term);

  // Terminal count for the current state (state length minus one).
  always_comb begin
    w_term = '0;
    case (r_state)
      ST_PWRUP:          w_term = CNT_W'(PWRUP_CYC - 1);
      ST_SETUP, ST_HOLD: w_term = CNT_W'(1);
      ST_STROBE:         w_term = CNT_W'(EN_CYC - 1);
      ST_WAIT:           w_term = w_is_clr ? CNT_W'(CLR_CYC - 1) : CNT_W'(CMD_CYC - 1);
      default:           w_term = '0;
    endcase
  end

  // Next-state logic plus the loads for the byte latched on SETUP entry.
  always_comb begin
    w_state_next = r_state;
    w_ld         = 1'b0;
    w_ld_data    = r_data;
    w_ld_rs      = r_rs;
    w_ld_kind    = r_kind;
    w_col_next   = r_col;
    w_idx_next   = r_idx;
    case (r_state)
      ST_PWRUP: begin
        if (w_cnt_done) begin
          w_state_next = ST_INIT;
          w_idx_next   = 3'd0;
        end
      end
      ST_INIT: begin
        w_state_next = ST_SETUP;
        w_ld         = 1'b1;
        w_ld_data    = init_cmd(r_idx);
        w_ld_rs      = 1'b0;
        w_ld_kind    = K_INIT;
      end
      ST_IDLE: begin
        if (VALID_I) begin
          w_state_next = ST_SETUP;
          w_ld         = 1'b1;
          w_ld_data    = DATA_I;
          w_ld_rs      = 1'b1;
          w_ld_kind    = K_CHAR;
`ifdef LCD_CTRL_CHAR_EN
          if (DATA_I == 8'h0D) begin
            // CR jumps to the start of the other line.
            w_ld_data  = r_col[4] ? 8'h80 : 8'hC0;
            w_ld_rs    = 1'b0;
            w_ld_kind  = K_CMD;
            w_col_next = r_col[4] ? 5'd0 : 5'd16;
          end else if (DATA_I == 8'h0C) begin
            // FF clears the display and homes the cursor.
            w_ld_data  = 8'h01;
            w_ld_rs    = 1'b0;
            w_ld_kind  = K_CMD;
            w_col_next = 5'd0;
          end
`endif
        end
      end
      ST_SETUP: begin
        if (w_cnt_done) w_state_next = ST_STROBE;
      end
      ST_STROBE: begin
        if (w_cnt_done) w_state_next = ST_HOLD;
      end
      ST_HOLD: begin
        if (w_cnt_done) w_state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (w_cnt_done) begin
          case (r_kind)
            K_INIT: begin
              if (r_idx == 3'd4) begin
                w_state_next = ST_IDLE;
              end else begin
                w_idx_next   = r_idx + 3'd1;
                w_state_next = ST_INIT;
              end
            end
            K_CHAR: begin
              w_col_next = w_col_inc;
              if ((w_col_inc == 5'd16) || (w_col_inc == 5'd0))
                w_state_next = ST_WRAP;
              else
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
          endcase
        end
      end
      ST_WRAP: begin
        // Column already advanced: 16 means line 2, 0 means back to line 1.
        w_state_next = ST_SETUP;
        w_ld         = 1'b1;
        w_ld_data    = (r_col == 5'd16) ? 8'hC0 : 8'h80;
        w_ld_rs      = 1'b0;
        w_ld_kind    = K_CMD;
      end
      default: w_state_next = ST_PWRUP;
    endcase
  end

  // State register.
  always_ff @(posedge CLK_I) begin
    if (RST_I) r_state <= ST_PWRUP;
    else       r_state <= w_state_next;
  end

  // Delay counter: restarts on every state change, saturates otherwise.
  always_ff @(posedge CLK_I) begin
    if (RST_I)                        r_cnt <= '0;
    else if (w_state_next != r_state) r_cnt <= '0;
    else if (r_cnt != '1)             r_cnt <= r_cnt + 1'b1;
  end

  // Datapath and pin registers; bus changes only when entering SETUP.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_idx       <= 3'd0;
      r_col       <= 5'd0;
      r_kind      <= K_INIT;
      r_rs        <= 1'b0;
      r_data      <= 8'h00;
      r_en        <= 1'b0;
      r_ready     <= 1'b0;
      r_init_done <= 1'b0;
    end else begin
      r_idx       <= w_idx_next;
      r_col       <= w_col_next;
      r_en        <= (w_state_next == ST_STROBE);
      r_ready     <= (w_state_next == ST_IDLE);
      r_init_done <= r_init_done | (w_state_next == ST_IDLE);
      if (w_ld) begin
        r_rs   <= w_ld_rs;
        r_data <= w_ld_data;
        r_kind <= w_ld_kind;
      end
    end
  end

  assign READY_O     = r_ready;
  assign INIT_DONE_O = r_init_done;
  assign LCD_RS_O    = r_rs;
  assign LCD_RW_O    = 1'b0;
  assign LCD_EN_O    = r_en;
  assign LCD_DATA_O  = r_data;

endmodule

// File: tb/tb_lcd_char_writer.sv
// Bench for lcd_char_writer with short timing parameters. A pin monitor
// records every EN pulse; a column-tracking model predicts the pulses and
// READY_O low time for each byte sent. Honors LCD_CTRL_CHAR_EN if defined.
module tb_lcd_char_writer;

  localparam int PWRUP = 100;
  localparam int CMD   = 10;
  localparam int CLR   = 40;
  localparam int EN    = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid = 1'b0;
  logic [7:0] din = 8'h00;
  logic       ready, init_done, rs, rw, en;
  logic [7:0] dout;

  lcd_char_writer #(
    .PWRUP_CYC(PWRUP), .CMD_CYC(CMD), .CLR_CYC(CLR), .EN_CYC(EN)
  ) dut (
    .CLK_I(clk), .RST_I(rst), .DATA_I(din), .VALID_I(valid),
    .READY_O(ready), .INIT_DONE_O(init_done), .LCD_RS_O(rs),
    .LCD_RW_O(rw), .LCD_EN_O(en), .LCD_DATA_O(dout)
  );

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         start;
    int         width;
    bit         stable;
  } pulse_t;

  typedef struct {
    logic       rs;
    logic [7:0] data;
  } exp_t;

  pulse_t mon_q[$];
  exp_t   exp_q[$];
  int     cyc = 0;
  int     checks = 0;
  int     errors = 0;
  int     m_col = 0;
  int     m_lo = 0;
  bit     m_exact = 1'b1;
  int     rel_cyc = 0;

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // EN pulse monitor, sampled on the falling edge.
  initial begin
    pulse_t cur;
    logic   prev_en;
    prev_en = 1'b0;
    cur = '{1'b0, 8'h00, 0, 0, 1'b1};
    forever begin
      @(negedge clk);
      if (en === 1'b1 && prev_en !== 1'b1) begin
        cur.rs = rs; cur.data = dout; cur.start = cyc; cur.width = 0; cur.stable = 1'b1;
      end
      if (en === 1'b1 && (rs !== cur.rs || dout !== cur.data)) cur.stable = 1'b0;
      if (en !== 1'b1 && prev_en === 1'b1) begin
        cur.width = cyc - cur.start;
        mon_q.push_back(cur);
      end
      prev_en = en;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d required completion", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_ge(input string tag, input int got, input int min);
    checks++;
    assert ((got >= min) === 1'b1) else begin
      errors++;
      $error("FAIL %s: got %0d expected >= %0d", tag, got, min);
    end
  endtask

  // Reference model: expected LCD writes for one accepted byte.
  task automatic model_byte(input logic [7:0] b);
    exp_t e;
    bit   handled;
    handled = 1'b0;
    exp_q.delete();
    m_exact = 1'b1;
    m_lo    = 4 + EN + CMD;
`ifdef LCD_CTRL_CHAR_EN
    if (b == 8'h0D) begin
      e.rs = 1'b0; e.data = (m_col < 16) ? 8'hC0 : 8'h80;
      exp_q.push_back(e);
      m_col = (m_col < 16) ? 16 : 0;
      handled = 1'b1;
    end else if (b == 8'h0C) begin
      e.rs = 1'b0; e.data = 8'h01;
      exp_q.push_back(e);
      m_col = 0;
      m_exact = 1'b0;
      m_lo = 4 + EN + CLR;
      handled = 1'b1;
    end
`endif
    if (!handled) begin
      e.rs = 1'b1; e.data = b;
      exp_q.push_back(e);
      m_col = (m_col + 1) % 32;
      if (m_col == 16 || m_col == 0) begin
        e.rs = 1'b0; e.data = (m_col == 16) ? 8'hC0 : 8'h80;
        exp_q.push_back(e);
        m_exact = 1'b0;
        m_lo = 2 * (4 + EN + CMD);
      end
    end
  endtask

  task automatic compare_pulses(input string tag);
    int n;
    check({tag, "_npulses"}, mon_q.size(), exp_q.size());
    n = (mon_q.size() < exp_q.size()) ? mon_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_rs"}, mon_q[i].rs, exp_q[i].rs);
      check({tag, "_data"}, mon_q[i].data, exp_q[i].data);
      check({tag, "_width"}, mon_q[i].width, EN);
      check({tag, "_stable"}, mon_q[i].stable, 1'b1);
    end
    mon_q.delete();
  endtask

  // Caller raises rst at a falling edge; this checks reset state and releases.
  task automatic do_reset();
    @(posedge clk); #1;
    valid = 1'b0;
    check("rst_en", en, 1'b0);
    check("rst_ready", ready, 1'b0);
    check("rst_rs", rs, 1'b0);
    check("rst_rw", rw, 1'b0);
    check("rst_data", dout, 8'h00);
    check("rst_init_done", init_done, 1'b0);
    @(posedge clk); #1;
    mon_q.delete();
    @(negedge clk);
    rst = 1'b0;
    rel_cyc = cyc;
    m_col = 0;
  endtask

  task automatic init_check();
    int   mism;
    exp_t e;
    mism = 0;
    for (int g = 0; g < 3000; g++) begin
      @(negedge clk);
      if (ready !== init_done) mism++;
      if (init_done === 1'b1) break;
    end
    check("init_done", init_done, 1'b1);
    check("init_ready_vs_done", mism, 0);
    exp_q.delete();
    e.rs = 1'b0;
    e.data = 8'h38; exp_q.push_back(e);
    e.data = 8'h38; exp_q.push_back(e);
    e.data = 8'h0C; exp_q.push_back(e);
    e.data = 8'h01; exp_q.push_back(e);
    e.data = 8'h06; exp_q.push_back(e);
    if (mon_q.size() == 5) begin
      check_ge("init_pwrup_wait", mon_q[0].start - rel_cyc, PWRUP);
      check_ge("init_clr_gap", mon_q[4].start - (mon_q[3].start + mon_q[3].width), CLR);
    end
    $display("init: pulses %0d ready/done mismatches %0d", mon_q.size(), mism);
    compare_pulses("init");
  endtask

  task automatic send_byte(input logic [7:0] b, input int txn);
    int lo;
    int hold;
    model_byte(b);
    @(negedge clk);
    for (int g = 0; g < 500 && ready !== 1'b1; g++) @(negedge clk);
    check("send_ready_wait", ready, 1'b1);
    valid = 1'b1;
    din   = b;
    hold  = $urandom_range(0, 3);
    @(posedge clk);
    lo = 0;
    for (int g = 0; g < 400; g++) begin
      @(negedge clk);
      if (g == hold) begin
        valid = 1'b0;
        din   = 8'($urandom);
      end
      if (ready === 1'b1) break;
      lo++;
    end
    check("send_ready_back", ready, 1'b1);
    if (m_exact) check("send_ready_low", lo, m_lo);
    else         check_ge("send_ready_low_min", lo, m_lo);
    $display("txn %0d: byte 0x%02h col->%0d pulses %0d ready_low %0d",
             txn, b, m_col, mon_q.size(), lo);
    compare_pulses("send");
  endtask

  initial begin
    int txn;
    txn = 0;
    rst = 1'b1;
    @(negedge clk);
    do_reset();
    init_check();

    send_byte(8'h41, txn++);

    // Reset in the middle of a character strobe.
    @(negedge clk);
    for (int g = 0; g < 500 && ready !== 1'b1; g++) @(negedge clk);
    valid = 1'b1;
    din   = 8'h42;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    for (int g = 0; g < 20 && en !== 1'b1; g++) @(negedge clk);
    check("midwrite_strobe_seen", en, 1'b1);
    rst = 1'b1;
    do_reset();
    init_check();

    for (int i = 0; i < 16; i++) send_byte(8'(8'h30 + i), txn++);
    for (int i = 0; i < 17; i++) send_byte(8'($urandom_range(32, 126)), txn++);

    rst = 1'b1;
    @(negedge clk);
    do_reset();
    init_check();
    send_byte(8'h0D, txn++);
    send_byte(8'h0C, txn++);
    for (int i = 0; i < 6; i++) send_byte(8'($urandom), txn++);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
